// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity modes.
// Reused by the transmit side so both ends agree on parity numbering.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the value presented while reset is held.
module uart_bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two register stages to let metastability settle before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with mid-bit start qualification,
// optional parity, 1 or 2 stop bits, parity and framing flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 received_byte,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_END = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_END = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_PAR  = (PARITY == PAR_ODD);
    localparam logic             HAS_PAR  = (PARITY != PAR_NONE);

    uart_rx_state_t       state;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 pend_perr;
    logic                 pend_ferr;
    logic                 bit_end;

    uart_bit_sync #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (bit_in),
        .q  (rx_s)
    );

    assign bit_end = (cnt == BIT_END);
    assign busy    = (state != RX_IDLE);

    // Frame FSM: counts clocks to mid-bit, samples, and publishes results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RX_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            pend_perr     <= 1'b0;
            pend_ferr     <= 1'b0;
            data_out      <= '0;
            received_byte <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            received_byte <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_END) begin
                        cnt       <= '0;
                        idx       <= '0;
                        pend_perr <= 1'b0;
                        pend_ferr <= 1'b0;
                        state     <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (idx == DATA_END) begin
                            idx   <= '0;
                            state <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        pend_perr <= ((^shreg) ^ rx_s) != ODD_PAR;
                        state     <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            pend_ferr <= 1'b1;
                        end
                        if (idx == STOP_END) begin
                            idx           <= '0;
                            data_out      <= shreg;
                            parity_err    <= pend_perr;
                            frame_err     <= pend_ferr | ~rx_s;
                            received_byte <= 1'b1;
                            state <= rx_s ? RX_IDLE : RX_WAIT_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: three configurations side by side,
// expected frames queued at send time and matched on each pulse.
module tb_uart_rx_core;

    localparam int CPB = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] line;

    logic [7:0] d0;
    logic       rb0, pe0, fe0, bz0;
    logic [7:0] d1;
    logic       rb1, pe1, fe1, bz1;
    logic [6:0] d2;
    logic       rb2, pe2, fe2, bz2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int pulse_cyc0 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_core dut0 (
        .clk(clk), .rst(rst), .bit_in(line[0]),
        .data_out(d0), .received_byte(rb0),
        .parity_err(pe0), .frame_err(fe0), .busy(bz0)
    );

    uart_rx_core #(.PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .bit_in(line[1]),
        .data_out(d1), .received_byte(rb1),
        .parity_err(pe1), .frame_err(fe1), .busy(bz1)
    );

    uart_rx_core #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .bit_in(line[2]),
        .data_out(d2), .received_byte(rb2),
        .parity_err(pe2), .frame_err(fe2), .busy(bz2)
    );

    // Scoreboard for the default receiver.
    always @(negedge clk) begin
        if (rb0) begin
            pulse_cyc0 = cyc;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected_pulse data=%h", d0);
            end else begin
                e0 = q0.pop_front();
                if ({d0, pe0, fe0} !== {e0.data[7:0], e0.perr, e0.ferr}) begin
                    errors++;
                    $display("FAIL dut0_frame got d=%h p=%b f=%b exp d=%h p=%b f=%b",
                             d0, pe0, fe0, e0.data[7:0], e0.perr, e0.ferr);
                end
            end
        end
    end

    // Scoreboard for the even-parity receiver.
    always @(negedge clk) begin
        if (rb1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_pulse data=%h", d1);
            end else begin
                e1 = q1.pop_front();
                if ({d1, pe1, fe1} !== {e1.data[7:0], e1.perr, e1.ferr}) begin
                    errors++;
                    $display("FAIL dut1_frame got d=%h p=%b f=%b exp d=%h p=%b f=%b",
                             d1, pe1, fe1, e1.data[7:0], e1.perr, e1.ferr);
                end
            end
        end
    end

    // Scoreboard for the 7-bit, 2-stop receiver.
    always @(negedge clk) begin
        if (rb2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL dut2_unexpected_pulse data=%h", d2);
            end else begin
                e2 = q2.pop_front();
                if ({d2, pe2, fe2} !== {e2.data[6:0], e2.perr, e2.ferr}) begin
                    errors++;
                    $display("FAIL dut2_frame got d=%h p=%b f=%b exp d=%h p=%b f=%b",
                             d2, pe2, fe2, e2.data[6:0], e2.perr, e2.ferr);
                end
            end
        end
    end

    // Builds one frame, queues its expected result, drives it bit by bit.
    task automatic send_frame(input int w, input int dbits,
                              input logic [8:0] data, input int par,
                              input logic flip, input int stops,
                              input logic stopv);
        logic [15:0] v;
        logic [8:0]  m;
        exp_t        ex;
        int          n;
        v = '0;
        n = 0;
        m = data & 9'((1 << dbits) - 1);
        v[n] = 1'b0;
        n++;
        for (int i = 0; i < dbits; i++) begin
            v[n] = m[i];
            n++;
        end
        if (par != 0) begin
            v[n] = (^m) ^ (par == 2) ^ flip;
            n++;
        end
        for (int i = 0; i < stops; i++) begin
            v[n] = stopv;
            n++;
        end
        ex.data = m;
        ex.perr = flip;
        ex.ferr = ~stopv;
        if (w == 0) q0.push_back(ex);
        else if (w == 1) q1.push_back(ex);
        else q2.push_back(ex);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            line[w] = v[i];
            if (i == 0) start_cyc = cyc;
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({d0, rb0, pe0, fe0, bz0} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut0 got %h exp 0", {d0, rb0, pe0, fe0, bz0});
        end
        checks++;
        if ({d1, rb1, pe1, fe1, bz1} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut1 got %h exp 0", {d1, rb1, pe1, fe1, bz1});
        end
        checks++;
        if ({d2, rb2, pe2, fe2, bz2} !== 11'h0) begin
            errors++;
            $display("FAIL reset_dut2 got %h exp 0", {d2, rb2, pe2, fe2, bz2});
        end
    endtask

    task automatic test_basic();
        send_frame(0, 8, 9'h0A5, 0, 1'b0, 1, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (pulse_cyc0 - start_cyc !== 155) begin
            errors++;
            $display("FAIL basic_latency got %0d exp 155", pulse_cyc0 - start_cyc);
        end
        checks++;
        if (q0.size() !== 0) begin
            errors++;
            $display("FAIL basic_pending got %0d exp 0", q0.size());
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        line[0] = 1'b0;
        repeat (4) @(negedge clk);
        line[0] = 1'b1;
        checks++;
        if (bz0 !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high got %b exp 1", bz0);
        end
        repeat (CPB / 2 + 1) @(negedge clk);
        checks++;
        if (bz0 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_low got %b exp 0", bz0);
        end
        checks++;
        if ({d0, pe0, fe0} !== {8'hA5, 2'b00}) begin
            errors++;
            $display("FAIL glitch_hold got %h exp %h", {d0, pe0, fe0}, {8'hA5, 2'b00});
        end
    endtask

    task automatic test_parity();
        send_frame(1, 8, 9'h003, 1, 1'b1, 1, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (pe1 !== 1'b1) begin
            errors++;
            $display("FAIL parity_bad got %b exp 1", pe1);
        end
        send_frame(1, 8, 9'h003, 1, 1'b0, 1, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (pe1 !== 1'b0) begin
            errors++;
            $display("FAIL parity_good got %b exp 0", pe1);
        end
    endtask

    task automatic test_frame_err();
        send_frame(0, 8, 9'h0C3, 0, 1'b0, 1, 1'b0);
        repeat (100) @(negedge clk);
        checks++;
        if ({bz0, fe0} !== 2'b11) begin
            errors++;
            $display("FAIL break_wait got busy=%b fe=%b exp 1 1", bz0, fe0);
        end
        line[0] = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (bz0 !== 1'b0) begin
            errors++;
            $display("FAIL break_release got %b exp 0", bz0);
        end
        send_frame(0, 8, 9'h05A, 0, 1'b0, 1, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({d0, fe0} !== {8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL break_recover got %h exp %h", {d0, fe0}, {8'h5A, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        send_frame(0, 8, 9'h055, 0, 1'b0, 1, 1'b1);
        send_frame(0, 8, 9'h0AA, 0, 1'b0, 1, 1'b1);
        send_frame(0, 8, 9'h0FF, 0, 1'b0, 1, 1'b1);
        send_frame(2, 7, 9'h055, 0, 1'b0, 2, 1'b1);
        send_frame(2, 7, 9'h0AA, 0, 1'b0, 2, 1'b1);
        send_frame(2, 7, 9'h0FF, 0, 1'b0, 2, 1'b1);
        repeat (30) @(negedge clk);
        checks++;
        if (q0.size() + q2.size() !== 0) begin
            errors++;
            $display("FAIL b2b_missing got %0d exp 0", q0.size() + q2.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        b = 8'h99;
        @(negedge clk);
        line[0] = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            line[0] = b[i];
            repeat ((i == 4) ? CPB / 2 : CPB - 1) @(negedge clk);
        end
        rst = 1'b1;
        line[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({d0, rb0, pe0, fe0, bz0} !== 12'h0) begin
            errors++;
            $display("FAIL midrst_dut0 got %h exp 0", {d0, rb0, pe0, fe0, bz0});
        end
        checks++;
        if (d1 !== 8'h00) begin
            errors++;
            $display("FAIL midrst_dut1 got %h exp 0", d1);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(0, 8, 9'h03C, 0, 1'b0, 1, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if ({d0, pe0, fe0, bz0, q0.size() == 0} !== {8'h3C, 4'b0001}) begin
            errors++;
            $display("FAIL midrst_after got d=%h p=%b f=%b b=%b exp d=3c 0 0 0",
                     d0, pe0, fe0, bz0);
        end
    endtask

    initial begin
        rst  = 1'b1;
        line = 3'b111;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
        repeat (10) @(negedge clk);
        checks++;
        if (q0.size() + q1.size() + q2.size() !== 0) begin
            errors++;
            $display("FAIL final_pending got %0d exp 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
